// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared operation encodings for the pipelined adder/subtractor
package addsub_pkg;

    // Operation select on i_op
    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - SW-bit combinational slice adder used once per pipeline stage
//
// Ports:
//   a, b  : SW-bit slice operands (b already conditionally inverted by the caller)
//   cin   : carry into the slice
//   sum   : SW-bit slice sum
//   cout  : carry out of the slice
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined two's-complement adder/subtractor with valid/ready handshake
//
// The WIDTH-bit carry chain is cut into STAGES equal slices; stage k adds
// slice k and passes its carry to stage k+1, so each stage only spans SW bits.
// All stages move together on a single global advance (no bubble collapsing).
//
// Parameters:
//   WIDTH  : operand/result width, multiple of STAGES
//   STAGES : number of pipeline stages (1..WIDTH)
//
// Ports:
//   i_clk, i_rst       : clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready  : input bundle handshake
//   i_op               : 0 = add, 1 = subtract
//   i_dataA, i_dataB   : operands
//   i_cin              : carry-in (1 for a true A-B)
//   o_valid / i_ready  : result handshake
//   o_res              : result
//   o_cout             : carry-out on add, borrow on subtract
//   o_ovf, o_zero      : signed overflow / result-is-zero
//
// Build option ADDSUB_FLAGS_EN: when defined, o_ovf and o_zero are computed and
// registered with the final stage; otherwise they are tied to 0.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_dataA,
    input  logic [WIDTH-1:0] i_dataB,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers. Operands travel whole; each stage only consumes its own slice.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bx_q  [STAGES];
    logic [WIDTH-1:0]  bx_d  [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [STAGES-1:0] c_q,   c_d;
    logic [STAGES-1:0] op_q,  op_d;
    logic [STAGES-1:0] vld_q, vld_d;

    // What each stage sees at its input: the input bundle for stage 0,
    // the previous stage's registers otherwise.
    logic [WIDTH-1:0]  in_a   [STAGES];
    logic [WIDTH-1:0]  in_bx  [STAGES];
    logic [WIDTH-1:0]  in_res [STAGES];
    logic [STAGES-1:0] in_c;
    logic [STAGES-1:0] in_op;
    logic [STAGES-1:0] in_vld;

    logic [SW-1:0]     sl_sum [STAGES];
    logic [STAGES-1:0] sl_cout;

    logic advance;

    assign o_valid = vld_q[LAST];
    assign advance = ~o_valid | i_ready;
    assign o_ready = advance;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : gen_stage
            if (k == 0) begin : gen_first
                assign in_a[k]   = i_dataA;
                assign in_bx[k]  = (i_op == ADDSUB_OP_SUB) ? ~i_dataB : i_dataB;
                assign in_res[k] = '0;
                assign in_c[k]   = i_cin;
                assign in_op[k]  = i_op;
                assign in_vld[k] = i_valid;
            end else begin : gen_next
                assign in_a[k]   = a_q[k-1];
                assign in_bx[k]  = bx_q[k-1];
                assign in_res[k] = res_q[k-1];
                assign in_c[k]   = c_q[k-1];
                assign in_op[k]  = op_q[k-1];
                assign in_vld[k] = vld_q[k-1];
            end

            addsub_slice #(
                .SW (SW)
            ) u_slice (
                .a    (in_a[k][k*SW +: SW]),
                .b    (in_bx[k][k*SW +: SW]),
                .cin  (in_c[k]),
                .sum  (sl_sum[k]),
                .cout (sl_cout[k])
            );
        end
    endgenerate

    always_comb begin
        c_d   = sl_cout;
        op_d  = in_op;
        vld_d = in_vld;
        for (int s = 0; s < STAGES; s++) begin
            a_d[s]   = in_a[s];
            bx_d[s]  = in_bx[s];
            res_d[s] = in_res[s];
            // Lower slices pass through; this stage fills in its own slice.
            res_d[s][s*SW +: SW] = sl_sum[s];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            c_q   <= '0;
            op_q  <= '0;
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                bx_q[s]  <= '0;
                res_q[s] <= '0;
            end
        end else if (advance) begin
            c_q   <= c_d;
            op_q  <= op_d;
            vld_q <= vld_d;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= a_d[s];
                bx_q[s]  <= bx_d[s];
                res_q[s] <= res_d[s];
            end
        end
    end

    assign o_res  = res_q[LAST];
    // The raw carry of A + ~B + 1 is "no borrow", so subtract reports its inverse.
    assign o_cout = (op_q[LAST] == ADDSUB_OP_SUB) ? ~c_q[LAST] : c_q[LAST];

`ifdef ADDSUB_FLAGS_EN
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    // Flags are formed from the final stage's next-state so they register
    // alongside the result and stay 0 after reset.
    always_comb begin
        ovf_d  = (in_a[LAST][WIDTH-1] == in_bx[LAST][WIDTH-1]) &&
                 (res_d[LAST][WIDTH-1] != in_a[LAST][WIDTH-1]);
        zero_d = (res_d[LAST] == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign o_ovf  = ovf_q;
    assign o_zero = zero_q;
`else
    assign o_ovf  = 1'b0;
    assign o_zero = 1'b0;
`endif

endmodule
